// File: rtl/pe_inject_eject_if_if.sv
// Bundle of every handshake and data signal between a PE, its network
// interface and the leaf port of the BTree switch fabric.
//
//   slave  : seen by the network interface (pe_inject_eject_if)
//   master : seen by whatever drives the interface (PE + switch side)
//
// Signals
//   i_pe_data/i_pe_valid, o_pe_ready     PE -> NI inject handshake
//   o_net_data/o_net_valid, i_net_ready  NI -> switch inject handshake
//   i_net_data/i_net_valid, o_net_ready  switch -> NI eject arrival
//   o_ej_data/o_ej_valid                 NI -> PE eject delivery
//   o_misroute                           sticky wrong-destination flag
//   o_inj_count/o_ej_count               traffic counters (0 unless stats built in)
interface pe_inject_eject_if_if #(
  parameter int TotalWidth = 35
);
  logic [TotalWidth-1:0] i_pe_data;
  logic                  i_pe_valid;
  logic                  o_pe_ready;
  logic [TotalWidth-1:0] o_net_data;
  logic                  o_net_valid;
  logic                  i_net_ready;
  logic [TotalWidth-1:0] i_net_data;
  logic                  i_net_valid;
  logic                  o_net_ready;
  logic [TotalWidth-1:0] o_ej_data;
  logic                  o_ej_valid;
  logic                  o_misroute;
  logic [31:0]           o_inj_count;
  logic [31:0]           o_ej_count;

  modport slave (
    input  i_pe_data, i_pe_valid, i_net_ready, i_net_data, i_net_valid,
    output o_pe_ready, o_net_data, o_net_valid, o_net_ready,
           o_ej_data, o_ej_valid, o_misroute, o_inj_count, o_ej_count
  );

  modport master (
    output i_pe_data, i_pe_valid, i_net_ready, i_net_data, i_net_valid,
    input  o_pe_ready, o_net_data, o_net_valid, o_net_ready,
           o_ej_data, o_ej_valid, o_misroute, o_inj_count, o_ej_count
  );
endinterface

// File: rtl/pe_inject_eject_if.sv
// Network interface between a processing element and its leaf port on the
// BTree switch fabric.
//   Inject: elastic first-word-fall-through FIFO (Depth entries) decoupling
//           PE issue from switch back-pressure.
//   Eject : one-cycle registered delivery of arriving packets to the PE plus
//           a sticky misroute flag when the destination field != address.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : pe_inject_eject_if_if.slave (all handshake/data signals)
//
// Build option
//   PE_IF_STATS_EN : when defined, saturating 32-bit counters of packets
//                    accepted by the switch and packets delivered to the PE;
//                    when undefined the counters do not exist and read 0.
module pe_inject_eject_if #(
  parameter int address      = 0,
  parameter int AddressWidth = 3,
  parameter int DataWidth    = 32,
  parameter int TotalWidth   = 35,
  parameter int Depth        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_inject_eject_if_if.slave     bus
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]           DEPTH_C = CW'(Depth);
  localparam logic [AddressWidth-1:0] ADDR_C  = AddressWidth'(address);

  logic [TotalWidth-1:0] mem [Depth];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pe_ready;
  logic                  net_valid;
  logic                  push;
  logic                  pop;

  logic [TotalWidth-1:0] ej_data_p1;
  logic                  ej_vld_p1;
  logic                  misroute;

  // Ready/valid come from the registered count only, so a pop in the same
  // cycle never opens a slot for a push: no combinational i_net_ready path.
  assign pe_ready  = (count != DEPTH_C);
  assign net_valid = (count != '0);
  assign push      = bus.i_pe_valid & pe_ready;
  assign pop       = net_valid & bus.i_net_ready;

  assign bus.o_pe_ready  = pe_ready;
  assign bus.o_net_valid = net_valid;
  assign bus.o_net_data  = mem[rd_ptr];
  assign bus.o_net_ready = 1'b1;

  // ---- inject stage: FIFO storage (data path, never reset) ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.i_pe_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- eject stage p1: registered delivery and misroute detection ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ej_vld_p1  <= 1'b0;
      ej_data_p1 <= '0;
      misroute   <= 1'b0;
    end else begin
      ej_vld_p1 <= bus.i_net_valid;
      if (bus.i_net_valid) begin
        ej_data_p1 <= bus.i_net_data;
        if (bus.i_net_data[DataWidth +: AddressWidth] != ADDR_C) misroute <= 1'b1;
      end
    end
  end

  assign bus.o_ej_data  = ej_data_p1;
  assign bus.o_ej_valid = ej_vld_p1;
  assign bus.o_misroute = misroute;

`ifdef PE_IF_STATS_EN
  logic [31:0] inj_cnt;
  logic [31:0] ej_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The eject counter steps on the same edge that raises o_ej_valid, so it
  // always equals the number of deliveries already visible to the PE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_cnt <= '0;
      ej_cnt  <= '0;
    end else begin
      if (pop)             inj_cnt <= sat_inc(inj_cnt);
      if (bus.i_net_valid) ej_cnt  <= sat_inc(ej_cnt);
    end
  end

  assign bus.o_inj_count = inj_cnt;
  assign bus.o_ej_count  = ej_cnt;
`else
  assign bus.o_inj_count = 32'd0;
  assign bus.o_ej_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pe_inject_eject_if.sv
module tb_pe_inject_eject_if;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int TW    = 35;
  localparam int DEPTH = 4;
  localparam int ADDR  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_inject_eject_if_if #(.TotalWidth(TW)) bus ();

  pe_inject_eject_if #(
    .address(ADDR), .AddressWidth(AW), .DataWidth(DW),
    .TotalWidth(TW), .Depth(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: the NI as a bounded queue plus the last eject delivery.
  logic [TW-1:0] q[$];
  logic [TW-1:0] sent[$];
  logic [TW-1:0] issued[$];
  logic          exp_ej_valid;
  logic [TW-1:0] exp_ej_data;
  logic          exp_mis;
  logic [31:0]   exp_inj;
  logic [31:0]   exp_ej;
  logic          prev_stall;
  logic [TW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_ej_valid = 1'b0;
    exp_ej_data  = '0;
    exp_mis      = 1'b0;
    exp_inj      = 32'd0;
    exp_ej       = 32'd0;
    prev_stall   = 1'b0;
    prev_data    = '0;
  endtask

  // Called at a falling edge with inputs already driven: compare, let the
  // rising edge happen, advance the model, return at the next falling edge.
  task automatic step();
    logic do_push;
    logic do_pop;
    check("pe_ready",  64'(bus.o_pe_ready),  64'(q.size() != DEPTH));
    check("net_valid", 64'(bus.o_net_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("net_data", 64'(bus.o_net_data), 64'(q[0]));
    if (prev_stall)    check("hold_data", 64'(bus.o_net_data), 64'(prev_data));
    check("net_ready", 64'(bus.o_net_ready), 64'(1));
    check("ej_valid",  64'(bus.o_ej_valid),  64'(exp_ej_valid));
    check("ej_data",   64'(bus.o_ej_data),   64'(exp_ej_data));
    check("misroute",  64'(bus.o_misroute),  64'(exp_mis));
`ifdef PE_IF_STATS_EN
    check("inj_count", 64'(bus.o_inj_count), 64'(exp_inj));
    check("ej_count",  64'(bus.o_ej_count),  64'(exp_ej));
`else
    check("inj_count", 64'(bus.o_inj_count), 64'(0));
    check("ej_count",  64'(bus.o_ej_count),  64'(0));
`endif
    do_push    = bus.i_pe_valid && (q.size() != DEPTH);
    do_pop     = (q.size() != 0) && bus.i_net_ready;
    prev_stall = (q.size() != 0) && !bus.i_net_ready;
    prev_data  = bus.o_net_data;
    @(posedge clk);
    if (do_pop) begin
      sent.push_back(q.pop_front());
      if (exp_inj != 32'hFFFF_FFFF) exp_inj++;
    end
    if (do_push) q.push_back(bus.i_pe_data);
    exp_ej_valid = bus.i_net_valid;
    if (bus.i_net_valid) begin
      exp_ej_data = bus.i_net_data;
      if (bus.i_net_data[DW +: AW] != AW'(ADDR)) exp_mis = 1'b1;
      if (exp_ej != 32'hFFFF_FFFF) exp_ej++;
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic acc;
    int cyc;

    // Reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_pe_data   = TW'({$urandom, $urandom});
      bus.i_pe_valid  = 1'($urandom);
      bus.i_net_ready = 1'($urandom);
      bus.i_net_data  = TW'({$urandom, $urandom});
      bus.i_net_valid = 1'($urandom);
      @(negedge clk);
      check("rst_pe_ready",  64'(bus.o_pe_ready),  64'(1));
      check("rst_net_valid", 64'(bus.o_net_valid), 64'(0));
      check("rst_ej_valid",  64'(bus.o_ej_valid),  64'(0));
      check("rst_ej_data",   64'(bus.o_ej_data),   64'(0));
      check("rst_misroute",  64'(bus.o_misroute),  64'(0));
      check("rst_inj_count", 64'(bus.o_inj_count), 64'(0));
    end
    bus.i_pe_valid  = 1'b0;
    bus.i_net_valid = 1'b0;
    bus.i_net_ready = 1'b0;
    bus.i_pe_data   = '0;
    bus.i_net_data  = '0;
    model_reset();
    rst = 1'b1;

    // Fill: switch stalled, five packets offered, fifth must wait
    sent.delete();
    k = 1;
    for (int c = 0; c < 8; c++) begin
      bus.i_pe_valid = 1'b1;
      bus.i_pe_data  = TW'(k);
      acc = bus.i_pe_valid && bus.o_pe_ready;
      step();
      if (acc) k++;
    end
    check("fill_accepted", 64'(k), 64'(5));
    check("fill_full_ready", 64'(bus.o_pe_ready), 64'(0));
    bus.i_net_ready = 1'b1;
    for (int c = 0; c < 20 && sent.size() < 5; c++) begin
      acc = bus.i_pe_valid && bus.o_pe_ready;
      step();
      if (acc) begin
        k++;
        if (k > 5) bus.i_pe_valid = 1'b0;
        else       bus.i_pe_data  = TW'(k);
      end
    end
    check("fill_drained", 64'(sent.size()), 64'(5));
    for (int i = 0; i < 5 && i < sent.size(); i++)
      check("fill_order", 64'(sent[i]), 64'(i + 1));

    // Stream: push every cycle into a free-running switch
    sent.delete();
    for (int i = 0; i < 20; i++) begin
      bus.i_pe_valid = 1'b1;
      bus.i_pe_data  = TW'(100 + i);
      step();
    end
    bus.i_pe_valid = 1'b0;
    step();
    step();
    check("stream_count", 64'(sent.size()), 64'(20));
    for (int i = 0; i < 20 && i < sent.size(); i++)
      check("stream_order", 64'(sent[i]), 64'(100 + i));

    // Eject: correctly addressed packet, then a misrouted one
    bus.i_net_valid = 1'b1;
    bus.i_net_data  = {3'd5, 32'hDEAD_BEEF};
    step();
    bus.i_net_valid = 1'b0;
    bus.i_net_data  = TW'({$urandom, $urandom});
    check("ej_good_data", 64'(bus.o_ej_data),  64'(35'h5_DEAD_BEEF));
    check("ej_good_vld",  64'(bus.o_ej_valid), 64'(1));
    check("ej_good_mis",  64'(bus.o_misroute), 64'(0));
    step();
    bus.i_net_valid = 1'b1;
    bus.i_net_data  = {3'd2, 32'h0000_0001};
    step();
    bus.i_net_valid = 1'b0;
    check("ej_bad_data", 64'(bus.o_ej_data),  64'(35'h2_0000_0001));
    check("ej_bad_mis",  64'(bus.o_misroute), 64'(1));
    for (int i = 0; i < 3; i++) step();
    check("ej_mis_sticky", 64'(bus.o_misroute), 64'(1));

    // Asynchronous reset with packets queued
    bus.i_net_ready = 1'b0;
    bus.i_pe_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_pe_data = TW'({$urandom, $urandom});
      step();
    end
    bus.i_pe_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.o_net_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_net_valid", 64'(bus.o_net_valid), 64'(0));
    check("arst_pe_ready",  64'(bus.o_pe_ready),  64'(1));
    check("arst_misroute",  64'(bus.o_misroute),  64'(0));
    check("arst_inj_count", 64'(bus.o_inj_count), 64'(0));
    check("arst_ej_count",  64'(bus.o_ej_count),  64'(0));
    @(negedge clk);
    model_reset();
    rst = 1'b1;

    // Random stall: 1000 packets, PE holds each offer until accepted
    sent.delete();
    issued.delete();
    bus.i_pe_valid = 1'b0;
    cyc = 0;
    while (sent.size() < 1000 && cyc < 20000) begin
      if (!bus.i_pe_valid && issued.size() < 1000 && $urandom_range(0, 3) != 0) begin
        bus.i_pe_valid = 1'b1;
        bus.i_pe_data  = TW'({$urandom, $urandom});
        issued.push_back(bus.i_pe_data);
      end
      bus.i_net_ready = 1'($urandom);
      acc = bus.i_pe_valid && bus.o_pe_ready;
      step();
      if (acc) bus.i_pe_valid = 1'b0;
      cyc++;
    end
    check("rand_drained", 64'(sent.size()), 64'(1000));
    k = 0;
    for (int i = 0; i < sent.size() && i < issued.size(); i++)
      if (sent[i] !== issued[i]) k++;
    check("rand_order_errors", 64'(k), 64'(0));

    // Ten correctly addressed deliveries
    bus.i_net_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.i_net_data = {3'(ADDR), $urandom};
      step();
    end
    bus.i_net_valid = 1'b0;
    step();
    check("final_misroute", 64'(bus.o_misroute), 64'(0));
`ifdef PE_IF_STATS_EN
    check("stats_inj_1000", 64'(bus.o_inj_count), 64'(1000));
    check("stats_ej_10",    64'(bus.o_ej_count),  64'(10));
    #2 rst = 1'b0;
    #1;
    check("stats_rst_inj", 64'(bus.o_inj_count), 64'(0));
    check("stats_rst_ej",  64'(bus.o_ej_count),  64'(0));
    check("stats_rst_vld", 64'(bus.o_net_valid), 64'(0));
    @(negedge clk);
    rst = 1'b1;
`else
    check("nostats_inj", 64'(bus.o_inj_count), 64'(0));
    check("nostats_ej",  64'(bus.o_ej_count),  64'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
